pc_next_unit: RTL and testbench

- Program-counter register plus next-PC selection logic for the 20-bit single-cycle MIPS core.
- Holds the word-indexed PC and produces the byte-address link value (PC+4) for jump-and-link writeback.
- Each cycle it selects the next PC from four sources: sequential, conditional branch, absolute jump, and jump-to-register.
- Built from three primitives: a 2-input AND gate, a 2:1 mux and a W-bit adder.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_next_unit_if.sv | 30 +++
 rtl/pc_add.sv | 12 +
 rtl/pc_mux2.sv | 13 +
 rtl/pc_next_unit.sv | 93 +++++++++
 tb/tb_pc_next_unit.sv | 239 +++++++++++++++++++++++
 6 files changed

// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the PC/next-PC unit.
// Purely declarative: no logic, no latency, no flow control.
package pc_pkg;

   localparam int W       = 20;
   localparam int PC_INCR = 4;

   typedef enum logic [1:0] {
      SRC_SEQ  = 2'd0,
      SRC_BR   = 2'd1,
      SRC_J    = 2'd2,
      SRC_JMEM = 2'd3
   } pc_src_e;

endpackage

// File: rtl/pc_next_unit_if.sv
// Control/target inputs and PC/link outputs of the next-PC unit.
// Plain wires, no handshake: the core consumes a new PC every cycle.
interface pc_next_unit_if
   import pc_pkg::*;
#(
   parameter int W = pc_pkg::W
);

   logic         branch;
   logic         zero_flag;
   logic         jump;
   logic         jmem;
   logic [W-1:0] sign_imm;
   logic [15:0]  jump_target;
   logic [W-1:0] reg_target;
   logic [W-1:0] pc;
   logic [W-1:0] link_addr;
   logic         branch_taken;

   modport master (
      output branch, zero_flag, jump, jmem, sign_imm, jump_target, reg_target,
      input  pc, link_addr, branch_taken
   );

   modport slave (
      input  branch, zero_flag, jump, jmem, sign_imm, jump_target, reg_target,
      output pc, link_addr, branch_taken
   );

endinterface

// File: rtl/pc_add.sv
// W-bit unsigned modular adder; combinational, no flow control.
module pc_add #(
   parameter int W = 20
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/pc_mux2.sv
// W-bit 2:1 mux, sel=1 picks b; combinational, no flow control.
module pc_mux2 #(
   parameter int W = 20
) (
   input  logic         sel,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/pc_next_unit.sv
// PC register with priority next-PC select (jmem > jump > branch > sequential).
// One-cycle redirect: selects are combinational, pc updates every rising edge, no stall.
module pc_next_unit
   import pc_pkg::*;
#(
   parameter int W = pc_pkg::W
) (
   input  logic          clk,
   input  logic          rst,
   pc_next_unit_if.slave bus
);

   logic [W-1:0] pc_q;
   logic [W-1:0] byte_pc;
   logic [W-1:0] link_addr;
   logic [W-1:0] br_offset;
   logic [W-1:0] branch_addr;
   logic [W-1:0] jump_addr;
   logic [W-1:0] mux_br;
   logic [W-1:0] mux_j;
   logic [W-1:0] next_byte;
   logic [W-1:0] pc_next;
   logic         branch_taken;
   pc_src_e      src;
   logic         unused_bits;

   // pc is a word index; the top two bits fall off when forming a byte address
   assign byte_pc   = {pc_q[W-3:0], 2'b00};
   assign br_offset = {bus.sign_imm[W-3:0], 2'b00};
   assign jump_addr = {{(W-18){1'b0}}, bus.jump_target, 2'b00};

   assign branch_taken = bus.branch & bus.zero_flag;

   pc_add #(.W(W)) u_add_link (
      .a   (byte_pc),
      .b   (W'(PC_INCR)),
      .sum (link_addr)
   );

   pc_add #(.W(W)) u_add_br (
      .a   (link_addr),
      .b   (br_offset),
      .sum (branch_addr)
   );

   always_comb begin
      src = SRC_SEQ;
      if (bus.jmem)
         src = SRC_JMEM;
      else if (bus.jump)
         src = SRC_J;
      else if (branch_taken)
         src = SRC_BR;
   end

   // Cascade order makes the last stage the highest priority
   pc_mux2 #(.W(W)) u_mux_br (
      .sel (src == SRC_BR),
      .a   (link_addr),
      .b   (branch_addr),
      .y   (mux_br)
   );

   pc_mux2 #(.W(W)) u_mux_j (
      .sel (src == SRC_J),
      .a   (mux_br),
      .b   (jump_addr),
      .y   (mux_j)
   );

   pc_mux2 #(.W(W)) u_mux_jmem (
      .sel (src == SRC_JMEM),
      .a   (mux_j),
      .b   (bus.reg_target),
      .y   (next_byte)
   );

   assign pc_next = next_byte >> 2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pc_q <= '0;
      else
         pc_q <= pc_next;
   end

   assign bus.pc           = pc_q;
   assign bus.link_addr    = link_addr;
   assign bus.branch_taken = branch_taken;

   assign unused_bits = ^{bus.sign_imm[W-1:W-2], next_byte[1:0]};

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit with hand-computed expectations.
module tb_pc_next_unit;

   localparam int W = 20;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   pc_next_unit_if #(.W(W)) bus ();

   pc_next_unit #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic idle_inputs();
      bus.branch      = 1'b0;
      bus.zero_flag   = 1'b0;
      bus.jump        = 1'b0;
      bus.jmem        = 1'b0;
      bus.sign_imm    = '0;
      bus.jump_target = '0;
      bus.reg_target  = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load pc with a word index via a jmem redirect
   task automatic load_pc(input logic [W-1:0] word);
      idle_inputs();
      bus.jmem       = 1'b1;
      bus.reg_target = word << 2;
      step();
      idle_inputs();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      step();
      step();
      checks++;
      if (bus.pc !== 20'h0) begin
         errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, 20'h0);
      end
      checks++;
      if (bus.link_addr !== 20'h4) begin
         errors++; $display("FAIL reset_link: got %h want %h", bus.link_addr, 20'h4);
      end
      bus.branch = 1'b1; bus.zero_flag = 1'b1;
      #1;
      checks++;
      if (bus.branch_taken !== 1'b1) begin
         errors++; $display("FAIL reset_bt_follows: got %b want 1", bus.branch_taken);
      end
      idle_inputs();
      #1;
      rst = 1'b1;
      step(); step(); step();
      checks++;
      if (bus.pc !== 20'h3) begin
         errors++; $display("FAIL seq3_pc: got %h want %h", bus.pc, 20'h3);
      end
      checks++;
      if (bus.link_addr !== 20'h10) begin
         errors++; $display("FAIL seq3_link: got %h want %h", bus.link_addr, 20'h10);
      end
   endtask

   task automatic test_branch();
      load_pc(20'h3);
      bus.branch = 1'b1; bus.zero_flag = 1'b1; bus.sign_imm = 20'h5;
      #1;
      checks++;
      if (bus.branch_taken !== 1'b1) begin
         errors++; $display("FAIL br_taken: got %b want 1", bus.branch_taken);
      end
      step();
      checks++;
      if (bus.pc !== 20'h9) begin
         errors++; $display("FAIL br_pc: got %h want %h", bus.pc, 20'h9);
      end
      load_pc(20'h3);
      bus.branch = 1'b1; bus.zero_flag = 1'b0; bus.sign_imm = 20'h5;
      #1;
      checks++;
      if (bus.branch_taken !== 1'b0) begin
         errors++; $display("FAIL br_not_taken_bt: got %b want 0", bus.branch_taken);
      end
      step();
      checks++;
      if (bus.pc !== 20'h4) begin
         errors++; $display("FAIL br_not_taken_pc: got %h want %h", bus.pc, 20'h4);
      end
   endtask

   task automatic test_neg_branch();
      load_pc(20'h9);
      bus.branch = 1'b1; bus.zero_flag = 1'b1; bus.sign_imm = 20'hFFFFE;
      step();
      checks++;
      if (bus.pc !== 20'h8) begin
         errors++; $display("FAIL neg_br_pc: got %h want %h", bus.pc, 20'h8);
      end
      idle_inputs();
   endtask

   task automatic test_jump();
      idle_inputs();
      bus.jump = 1'b1; bus.jump_target = 16'h0040;
      step();
      checks++;
      if (bus.pc !== 20'h00040) begin
         errors++; $display("FAIL jump_pc: got %h want %h", bus.pc, 20'h00040);
      end
      bus.jump = 1'b1; bus.jump_target = 16'h0040;
      bus.jmem = 1'b1; bus.reg_target = 20'h00024;
      step();
      checks++;
      if (bus.pc !== 20'h9) begin
         errors++; $display("FAIL jmem_prio_pc: got %h want %h", bus.pc, 20'h9);
      end
      // jump beats a taken branch
      idle_inputs();
      bus.jump = 1'b1; bus.jump_target = 16'h0123;
      bus.branch = 1'b1; bus.zero_flag = 1'b1; bus.sign_imm = 20'h5;
      step();
      checks++;
      if (bus.pc !== 20'h00123) begin
         errors++; $display("FAIL jump_over_branch_pc: got %h want %h", bus.pc, 20'h00123);
      end
      idle_inputs();
      bus.jmem = 1'b1; bus.reg_target = 20'h00027;
      step();
      checks++;
      if (bus.pc !== 20'h9) begin
         errors++; $display("FAIL jmem_low_bits_pc: got %h want %h", bus.pc, 20'h9);
      end
      idle_inputs();
   endtask

   task automatic test_wrap();
      idle_inputs();
      bus.jmem = 1'b1; bus.reg_target = 20'hFFFFC;
      step();
      idle_inputs();
      #1;
      checks++;
      if (bus.pc !== 20'h3FFFF) begin
         errors++; $display("FAIL wrap_load_pc: got %h want %h", bus.pc, 20'h3FFFF);
      end
      checks++;
      if (bus.link_addr !== 20'h0) begin
         errors++; $display("FAIL wrap_link: got %h want %h", bus.link_addr, 20'h0);
      end
      step();
      checks++;
      if (bus.pc !== 20'h0) begin
         errors++; $display("FAIL wrap_pc: got %h want %h", bus.pc, 20'h0);
      end
   endtask

   task automatic test_async_reset();
      load_pc(20'h9);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.pc !== 20'h0) begin
         errors++; $display("FAIL arst_pc: got %h want %h", bus.pc, 20'h0);
      end
      checks++;
      if (bus.link_addr !== 20'h4) begin
         errors++; $display("FAIL arst_link: got %h want %h", bus.link_addr, 20'h4);
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.pc !== 20'h0) begin
         errors++; $display("FAIL arst_release_hold: got %h want %h", bus.pc, 20'h0);
      end
      step();
      checks++;
      if (bus.pc !== 20'h1) begin
         errors++; $display("FAIL arst_release_pc: got %h want %h", bus.pc, 20'h1);
      end
   endtask

   task automatic test_back_to_back();
      // Redirect every cycle: jump, branch back, then sequential
      load_pc(20'h10);
      bus.jump = 1'b1; bus.jump_target = 16'h0020;
      step();
      idle_inputs();
      bus.branch = 1'b1; bus.zero_flag = 1'b1; bus.sign_imm = 20'hFFFF0;
      step();
      checks++;
      if (bus.pc !== 20'h11) begin
         errors++; $display("FAIL b2b_branch_pc: got %h want %h", bus.pc, 20'h11);
      end
      idle_inputs();
      step();
      checks++;
      if (bus.pc !== 20'h12) begin
         errors++; $display("FAIL b2b_seq_pc: got %h want %h", bus.pc, 20'h12);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_branch();
      test_neg_branch();
      test_jump();
      test_wrap();
      test_async_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
